// File: rtl/traffic_pkg.sv
// Shared constants and types for the traffic generator.
// Optional feature macro: TRAFFIC_RANDOM_EN (LFSR-driven skip after a lane wraps).
package traffic_pkg;

  localparam int H_DISPLAY = 640;
  localparam int CAR_WIDTH = 32;
  localparam int SPAN      = H_DISPLAY + CAR_WIDTH;
  localparam int LEVEL_MAX = 7;
  localparam int NUM_LANES = 8;

  localparam logic [9:0] SPAN_W = 10'(SPAN);

  // Index 0 is lane 1.
  localparam logic [7:0][3:0] LANE_STEP = {4'd2, 4'd3, 4'd1, 4'd4, 4'd2, 4'd3, 4'd2, 4'd1};
  localparam logic [7:0][9:0] LANE_INIT_X = {10'd560, 10'd480, 10'd400, 10'd320,
                                             10'd240, 10'd160, 10'd80,  10'd0};
  // 1 = moves right (odd lanes), 0 = moves left (even lanes).
  localparam logic [7:0] LANE_DIR_RIGHT = 8'b0101_0101;

  typedef enum logic {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } state_e;

`ifdef TRAFFIC_RANDOM_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction
`endif

endpackage

// File: rtl/lane_mover.sv
// One traffic lane: holds the car x-position and wraps it across the span.
// Optional feature macro: TRAFFIC_RANDOM_EN (per-lane skip counter).
module lane_mover
  import traffic_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       tick_i,
  input  logic       enable_i,
  input  logic [3:0] step_i,
  input  logic       dir_i,
  input  logic       load_i,
  input  logic [9:0] init_i,
`ifdef TRAFFIC_RANDOM_EN
  input  logic [1:0] rnd_i,
  input  logic       skip_clr_i,
`endif
  output logic [9:0] x_o,
  output logic       wrap_o
);

  logic [9:0] x_q, x_d;
  logic [9:0] step_s;
  logic [9:0] nxt_s;
  logic       wrap_s;
  logic       move_s;

  assign step_s = {6'd0, step_i};

  // Candidate next position and wrap detection; sums never exceed 682 so 10 bits suffice.
  always_comb begin
    nxt_s  = x_q;
    wrap_s = 1'b0;
    if (dir_i) begin
      if ((x_q + step_s) >= SPAN_W) begin
        wrap_s = 1'b1;
        nxt_s  = x_q + step_s - SPAN_W;
      end else begin
        nxt_s  = x_q + step_s;
      end
    end else begin
      if (x_q < step_s) begin
        wrap_s = 1'b1;
        nxt_s  = x_q + SPAN_W - step_s;
      end else begin
        nxt_s  = x_q - step_s;
      end
    end
  end

`ifdef TRAFFIC_RANDOM_EN
  logic [1:0] skip_q, skip_d;

  assign move_s = tick_i & enable_i & (skip_q == 2'd0);

  // Skip counter: loads random hold length on a wrap, counts down on ticks while non-zero.
  always_comb begin
    skip_d = skip_q;
    if (load_i || skip_clr_i) begin
      skip_d = 2'd0;
    end else if (tick_i && enable_i) begin
      if (skip_q != 2'd0) begin
        skip_d = skip_q - 2'd1;
      end else if (wrap_s) begin
        skip_d = rnd_i;
      end else begin
        skip_d = skip_q;
      end
    end else begin
      skip_d = skip_q;
    end
  end

  // Skip counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) skip_q <= 2'd0;
    else     skip_q <= skip_d;
  end
`else
  assign move_s = tick_i & enable_i;
`endif

  // Position next-state: reload dominates movement.
  always_comb begin
    x_d = x_q;
    if (load_i) begin
      x_d = init_i;
    end else if (move_s) begin
      x_d = nxt_s;
    end else begin
      x_d = x_q;
    end
  end

  // Position register (init value is a tied-off constant at the top level).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) x_q <= init_i;
    else     x_q <= x_d;
  end

  assign x_o    = x_q;
  assign wrap_o = move_s & wrap_s;

endmodule

// File: rtl/traffic_control.sv
// Traffic generator: tick divider, RUN/FREEZE FSM, level register and eight lane movers.
// Optional feature macro: TRAFFIC_RANDOM_EN (LFSR advancing each tick feeds lane skip counters).
module traffic_control
  import traffic_pkg::*;
#(
  parameter int TICK_PERIOD  = 250000,
  parameter int FREEZE_TICKS = 60
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       game_reset,
  input  logic       level_up,
  input  logic       freeze_req,
  output logic [9:0] car_x1,
  output logic [9:0] car_x2,
  output logic [9:0] car_x3,
  output logic [9:0] car_x4,
  output logic [9:0] car_x5,
  output logic [9:0] car_x6,
  output logic [9:0] car_x7,
  output logic [9:0] car_x8,
  output logic [2:0] level,
  output logic       frozen
);

  localparam int TW = $clog2(TICK_PERIOD);
  localparam int FW = $clog2(FREEZE_TICKS + 1);

  logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [FW-1:0]  freeze_cnt_q, freeze_cnt_d;
  logic [2:0]     level_q, level_d;
  state_e         state_q, state_d;
  logic           tick_s;
  logic           move_en_s;
  logic [9:0]     x_s [NUM_LANES];
  logic [3:0]     step_s [NUM_LANES];
  logic [NUM_LANES-1:0] wrap_s;
  logic           wrap_unused_s;

  assign tick_s        = (tick_cnt_q == TW'(TICK_PERIOD - 1));
  assign wrap_unused_s = ^wrap_s;

  // Next-state for tick counter, level and RUN/FREEZE FSM; game_reset overrides everything.
  always_comb begin
    tick_cnt_d   = tick_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    level_d      = level_q;
    state_d      = state_q;
    move_en_s    = 1'b0;
    if (game_reset) begin
      tick_cnt_d   = '0;
      freeze_cnt_d = '0;
      level_d      = 3'd0;
      state_d      = RUN;
    end else begin
      tick_cnt_d = tick_s ? '0 : tick_cnt_q + TW'(1);
      if (level_up && (level_q != 3'(LEVEL_MAX))) begin
        level_d = level_q + 3'd1;
      end else begin
        level_d = level_q;
      end
      case (state_q)
        RUN: begin
          if (freeze_req) begin
            state_d      = FREEZE;
            freeze_cnt_d = FW'(FREEZE_TICKS);
          end else begin
            move_en_s = 1'b1;
          end
        end
        FREEZE: begin
          if (freeze_req) begin
            freeze_cnt_d = FW'(FREEZE_TICKS);
          end else if (tick_s) begin
            freeze_cnt_d = freeze_cnt_q - FW'(1);
            if (freeze_cnt_q <= FW'(1)) begin
              freeze_cnt_d = '0;
              state_d      = RUN;
            end else begin
              state_d      = FREEZE;
            end
          end else begin
            freeze_cnt_d = freeze_cnt_q;
          end
        end
        default: begin
          state_d      = RUN;
          freeze_cnt_d = '0;
        end
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tick_cnt_q   <= '0;
      freeze_cnt_q <= '0;
      level_q      <= 3'd0;
      state_q      <= RUN;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
      level_q      <= level_d;
      state_q      <= state_d;
    end
  end

`ifdef TRAFFIC_RANDOM_EN
  logic [15:0] lfsr_q, lfsr_d;

  // LFSR next-state: reseed on game_reset, advance every tick.
  always_comb begin
    lfsr_d = lfsr_q;
    if (game_reset) begin
      lfsr_d = LFSR_SEED;
    end else if (tick_s) begin
      lfsr_d = lfsr_next(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign step_s[i] = LANE_STEP[i] + {1'b0, level_q};

    lane_mover u_lane (
      .CLK        (CLK),
      .RST        (RST),
      .tick_i     (tick_s),
      .enable_i   (move_en_s),
      .step_i     (step_s[i]),
      .dir_i      (LANE_DIR_RIGHT[i]),
      .load_i     (game_reset),
      .init_i     (LANE_INIT_X[i]),
`ifdef TRAFFIC_RANDOM_EN
      .rnd_i      (lfsr_q[1:0]),
      .skip_clr_i (freeze_req),
`endif
      .x_o        (x_s[i]),
      .wrap_o     (wrap_s[i])
    );
  end

  assign car_x1 = x_s[0];
  assign car_x2 = x_s[1];
  assign car_x3 = x_s[2];
  assign car_x4 = x_s[3];
  assign car_x5 = x_s[4];
  assign car_x6 = x_s[5];
  assign car_x7 = x_s[6];
  assign car_x8 = x_s[7];
  assign level  = level_q;
  assign frozen = (state_q == FREEZE);

endmodule

// File: tb/tb_traffic_control.sv
// Self-checking bench for traffic_control: directed scenarios plus random pulses,
// compared every cycle against a behavioural model of car motion.
module tb_traffic_control;

  localparam int TP   = 4;
  localparam int FT   = 3;
  localparam int SPAN = 672;

  logic       CLK = 1'b0;
  logic       RST;
  logic       game_reset, level_up, freeze_req;
  logic [9:0] car_x1, car_x2, car_x3, car_x4, car_x5, car_x6, car_x7, car_x8;
  logic [2:0] level;
  logic       frozen;

  always #5 CLK = ~CLK;

  traffic_control #(.TICK_PERIOD(TP), .FREEZE_TICKS(FT)) dut (
    .CLK(CLK), .RST(RST), .game_reset(game_reset), .level_up(level_up),
    .freeze_req(freeze_req),
    .car_x1(car_x1), .car_x2(car_x2), .car_x3(car_x3), .car_x4(car_x4),
    .car_x5(car_x5), .car_x6(car_x6), .car_x7(car_x7), .car_x8(car_x8),
    .level(level), .frozen(frozen)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model
  int lane_step [8] = '{1, 2, 3, 2, 4, 1, 3, 2};
  int m_pos [8];
  int m_lvl, m_left, m_phase;
  bit m_frz;
  int saved;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_vec++;
    if (obs !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] dut_x(input int i);
    case (i)
      0: return car_x1;
      1: return car_x2;
      2: return car_x3;
      3: return car_x4;
      4: return car_x5;
      5: return car_x6;
      6: return car_x7;
      default: return car_x8;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_pos[i] = i * 80;
    m_lvl = 0; m_left = 0; m_phase = 0; m_frz = 1'b0;
  endtask

  // One clock of the model: ticks every TP cycles; odd lanes +step, even lanes -step, modulo SPAN.
  task automatic model_step(input bit gr, input bit lu, input bit fr);
    bit tick;
    int old_lvl;
    tick = (m_phase == TP - 1);
    if (gr) begin
      model_reset();
      return;
    end
    m_phase = (m_phase + 1) % TP;
    old_lvl = m_lvl;
    if (lu && m_lvl < 7) m_lvl++;
    if (fr) begin
      m_frz  = 1'b1;
      m_left = FT;
    end else if (m_frz) begin
      if (tick) begin
        m_left--;
        if (m_left == 0) m_frz = 1'b0;
      end
    end else if (tick) begin
      for (int i = 0; i < 8; i++) begin
        if (i % 2 == 0) m_pos[i] = (m_pos[i] + lane_step[i] + old_lvl) % SPAN;
        else            m_pos[i] = (m_pos[i] - lane_step[i] - old_lvl + SPAN) % SPAN;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s_x%0d", tag, i + 1), dut_x(i), m_pos[i]);
    check({tag, "_level"}, level, m_lvl);
    check({tag, "_frozen"}, frozen, int'(m_frz));
  endtask

  task automatic cyc(input bit gr, input bit lu, input bit fr);
    game_reset = gr; level_up = lu; freeze_req = fr;
    model_step(gr, lu, fr);
    @(posedge CLK);
    @(negedge CLK);
    game_reset = 1'b0; level_up = 1'b0; freeze_req = 1'b0;
    check_all("run");
  endtask

  task automatic align();
    while (m_phase != 0) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    RST = 1'b1; game_reset = 1'b0; level_up = 1'b0; freeze_req = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    check_all("reset");
    RST = 1'b0;

    // First tick after reset release
    repeat (TP) cyc(1'b0, 1'b0, 1'b0);
    check("first_x1", car_x1, 1);
    check("first_x2", car_x2, 78);
    check("first_x5", car_x5, 324);

    // Long level-0 run: lane 1 wraps 671->0, lane 8 wraps 0->670
    repeat (700 * TP) cyc(1'b0, 1'b0, 1'b0);

    // Level saturation and step 11 on lane 5
    repeat (9) cyc(1'b0, 1'b1, 1'b0);
    check("level_sat", level, 7);
    align();
    saved = m_pos[4];
    repeat (TP) cyc(1'b0, 1'b0, 1'b0);
    check("lvl7_x5", car_x5, (saved + 11) % SPAN);

    // Freeze for FT ticks, then movement resumes on the next tick
    align();
    saved = m_pos[4];
    cyc(1'b0, 1'b0, 1'b1);
    check("frz_on", frozen, 1);
    repeat (FT * TP - 2) cyc(1'b0, 1'b0, 1'b0);
    check("frz_still", frozen, 1);
    cyc(1'b0, 1'b0, 1'b0);
    check("frz_off", frozen, 0);
    check("frz_hold_x5", car_x5, saved);
    repeat (TP) cyc(1'b0, 1'b0, 1'b0);
    check("frz_resume_x5", car_x5, (saved + 11) % SPAN);

    // Retrigger after 2 ticks: hold extends to 5 ticks
    align();
    saved = m_pos[0];
    cyc(1'b0, 1'b0, 1'b1);
    repeat (2 * TP - 1) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    repeat (FT * TP - 2) cyc(1'b0, 1'b0, 1'b0);
    check("retrig_still", frozen, 1);
    cyc(1'b0, 1'b0, 1'b0);
    check("retrig_off", frozen, 0);
    check("retrig_hold_x1", car_x1, saved);

    // game_reset together with freeze_req and level_up
    cyc(1'b1, 1'b1, 1'b1);
    check("grst_x1", car_x1, 0);
    check("grst_x8", car_x8, 560);
    check("grst_level", level, 0);
    check("grst_frozen", frozen, 0);

    // Random pulses
    for (int n = 0; n < 4000; n++) begin
      cyc($urandom_range(0, 399) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 149) == 0);
    end

    // Async reset between clock edges
    cyc(1'b0, 1'b0, 1'b1);
    #2;
    RST = 1'b1;
    #1;
    check("arst_x2", car_x2, 80);
    check("arst_x5", car_x5, 320);
    check("arst_level", level, 0);
    check("arst_frozen", frozen, 0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    check_all("arst");
    repeat (3 * TP) cyc(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/traffic_control.md
Name: traffic_control

Overview:
- Upstream neighbour of the player/score stage: generates the eight car x-positions (car_x1..car_x8) that the player stage uses for collision checks and that the video stage renders.
- Each lane moves at its own base speed, alternating direction per lane. Speed rises with the game level.
- Traffic freezes briefly after a collision.
- Lane y-positions are fixed constants owned by the player/video stages; this block produces x only.

Parameters:
- H_DISPLAY, 640, visible width in pixels.
- CAR_WIDTH, 32, car sprite width; wrap span SPAN = H_DISPLAY + CAR_WIDTH = 672.
- TICK_PERIOD, 250000, CLK cycles per movement tick (must be ≥ 2).
- LEVEL_MAX, 7, saturation value of level.
- FREEZE_TICKS, 60, ticks of traffic halt after a collision.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-high reset.
- game_reset  in  1  single-cycle pulse: restart traffic and clear the level.
- level_up  in  1  single-cycle pulse on a successful crossing.
- freeze_req  in  1  single-cycle pulse on a player collision.
- car_x1..car_x8  out  10 each  car left-edge x, range 0..SPAN-1.
- level  out  3  current level, 0..LEVEL_MAX.
- frozen  out  1  high while in the FREEZE state.

Behaviour:
- Reset (RST high, async) and game_reset (sync) load the same values:
  - car_xN = ((N-1)*80) mod SPAN, i.e. 0, 80, 160 .. 560.
  - level = 0, tick_cnt = 0, freeze_cnt = 0, state = RUN, frozen = 0.
  - Under TRAFFIC_RANDOM_EN, all skip counters = 0 and the LFSR seed = 16'hACE1.
- Tick generation:
  - tick_cnt counts 0..TICK_PERIOD-1 and then wraps.
  - tick is asserted for one cycle when tick_cnt = TICK_PERIOD-1.
- Step size: stepN = LANE_STEP[N] + level (max 4+7 = 11). All arithmetic is 10-bit unsigned; no intermediate value exceeds 682.
- Direction: odd lanes move right, even lanes move left.
- Right-moving lane, on a tick in RUN:
  - if x + step ≥ SPAN, x ← x + step − SPAN;
  - else x ← x + step.
- Left-moving lane, on a tick in RUN:
  - if x < step, x ← x + SPAN − step;
  - else x ← x − step.
- Outputs are registered. A position changes in the cycle after tick is high, so latency is 1 cycle.
- FSM with two states, RUN and FREEZE:
  - RUN → FREEZE on freeze_req; freeze_cnt ← FREEZE_TICKS.
  - In FREEZE, positions hold. Each tick decrements freeze_cnt; when freeze_cnt reaches 0 on a tick, the state returns to RUN. Movement resumes on the next tick.
  - freeze_req while already in FREEZE reloads freeze_cnt to FREEZE_TICKS (retrigger).
  - frozen = (state == FREEZE).
- Level: level_up increments level, saturating at LEVEL_MAX. It is accepted in either state.
- Simultaneous events, priority highest first: RST > game_reset > freeze_req > movement. level_up in the same cycle as freeze_req is still applied. A tick coinciding with freeze_req produces no movement.

Optional Feature:
- Macro: TRAFFIC_RANDOM_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every tick.
  - When a lane wraps, its 2-bit skip counter loads lfsr[1:0].
  - While a lane's skip counter is non-zero, that lane holds position for that many ticks, and the counter decrements on each tick.
  - freeze_req and game_reset clear all skip counters.
- Undefined: no LFSR and no skip counters; motion is fully deterministic as described above.

Decomposition:
- Package traffic_pkg:
  - LANE_STEP constant array {1,2,3,2,4,1,3,2};
  - LANE_INIT_X array;
  - lane direction bit array;
  - state enum {RUN, FREEZE}.
- Sub-module lane_mover, instantiated 8 times:
  - inputs: tick, enable, step, direction, load, init value;
  - output: its x register and a wrap flag;
  - holds the skip counter when TRAFFIC_RANDOM_EN is defined.
- The top level holds the tick counter, FSM, level register and LFSR.

Test Plan:
- Bench parameters are TICK_PERIOD=4 and FREEZE_TICKS=3 throughout.
- Reset release, then 1 tick: car_x1=1, car_x2=80−2=78, car_x5=320+4=324, level=0, frozen=0.
- Right wrap: lane 1 preloaded to x=671, level=0, one tick → car_x1=0.
- Left wrap: lane 8 preloaded to x=1 (step 2) → 671; lane 8 at x=0 → 670.
- level_up ×9 → level saturates at 7; next tick moves lane 5 by 11 (324 → 335).
- freeze_req → frozen=1 and positions hold for 3 ticks. A second freeze_req after 2 ticks extends the hold to 5 ticks total; movement resumes on the tick after frozen falls.
- game_reset coinciding with freeze_req and level_up → all outputs return to reset values, frozen=0, level=0. An async RST mid-tick clears everything immediately, without waiting for CLK.
